ceespu_sdram_arbiter: RTL

//  Shares the single SDRAM controller between the instruction-cache refill port (I, read-only)
//  and the data port (D, read/write). Grants one owner at a time; refill bursts hold ownership
//  via a lock input. Read responses return in order and are routed back through a tag FIFO.

---
 rtl/ceespu_sdram_arbiter_if.sv | 53 +++++
 rtl/ceespu_sdram_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ceespu_sdram_arbiter_if.sv
// Bus bundle between the arbiter and its two requesters plus the SDRAM controller.
// Handshake: a requester holds I_x_req (with addr/we/wdata stable) until a cycle
// where O_x_busy is low; that cycle is the single transfer and O_sdram_new_command
// pulses with it. O_x_valid is a one-cycle read-data strobe with no back-pressure.
interface ceespu_sdram_arbiter_if;
  // I-port (instruction-cache refill, read-only)
  logic        I_i_req;
  logic        I_i_lock;
  logic [22:0] I_i_addr;
  logic        O_i_busy;
  logic        O_i_valid;
  logic [31:0] O_i_data;
  // D-port (data path, read/write)
  logic        I_d_req;
  logic        I_d_lock;
  logic [22:0] I_d_addr;
  logic        I_d_we;
  logic [31:0] I_d_wdata;
  logic        O_d_busy;
  logic        O_d_valid;
  logic [31:0] O_d_data;
  // SDRAM controller side
  logic [22:0] O_sdram_addr;
  logic        O_sdram_new_command;
  logic        O_sdram_we;
  logic [31:0] O_sdram_wdata;
  logic        I_sdram_busy;
  logic        I_sdram_valid;
  logic [31:0] I_sdram_data;
  logic        O_err;

  // Arbiter side
  modport slave (
    input  I_i_req, I_i_lock, I_i_addr,
    output O_i_busy, O_i_valid, O_i_data,
    input  I_d_req, I_d_lock, I_d_addr, I_d_we, I_d_wdata,
    output O_d_busy, O_d_valid, O_d_data,
    output O_sdram_addr, O_sdram_new_command, O_sdram_we, O_sdram_wdata,
    input  I_sdram_busy, I_sdram_valid, I_sdram_data,
    output O_err
  );

  // Requester / controller-model side
  modport master (
    output I_i_req, I_i_lock, I_i_addr,
    input  O_i_busy, O_i_valid, O_i_data,
    output I_d_req, I_d_lock, I_d_addr, I_d_we, I_d_wdata,
    input  O_d_busy, O_d_valid, O_d_data,
    input  O_sdram_addr, O_sdram_new_command, O_sdram_we, O_sdram_wdata,
    output I_sdram_busy, I_sdram_valid, I_sdram_data,
    input  O_err
  );
endinterface

// File: rtl/ceespu_sdram_arbiter.sv
// Two-port SDRAM arbiter: one owner at a time, lock keeps a refill burst intact,
// HOLD_MAX bounds how long an unlocked owner can starve the other port, and a
// tag FIFO routes in-order read responses back to the port that issued them.
module ceespu_sdram_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int HOLD_MAX    = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  ceespu_sdram_arbiter_if.slave bus,
  output logic [1:0]           dbg_state_o
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM  = HOLD_MAX[HW-1:0];
  localparam logic [PW:0]   FIFO_LIM  = OUTSTANDING[PW:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: D was the last owner
  logic [HW-1:0] hold_q, hold_d;

  // Tag FIFO: 0 = response belongs to I, 1 = belongs to D
  logic          tag_mem_q [OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          err_q;

  logic        own_d, req_x, lock_x, other_req, read_x, preempt;
  logic        accept, push, push_tag, pop, head_tag;
  logic        fifo_full, fifo_empty;
  logic        new_cmd, cmd_we, i_busy, d_busy;
  logic [22:0] cmd_addr;
  logic [31:0] cmd_wdata;

  assign fifo_full  = (count_q == FIFO_LIM);
  assign fifo_empty = (count_q == '0);

  // Owner-relative views of the request inputs
  always_comb begin
    own_d     = (state_q == ST_OWN_D);
    req_x     = own_d ? bus.I_d_req  : bus.I_i_req;
    lock_x    = own_d ? bus.I_d_lock : bus.I_i_lock;
    other_req = own_d ? bus.I_i_req  : bus.I_d_req;
    read_x    = own_d ? ~bus.I_d_we  : 1'b1;
    // Unlocked owner that has used its quota yields to a waiting port
    preempt   = ~lock_x & other_req & (hold_q >= HOLD_LIM);
  end

  // Next-state, command mux and busy flags
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    hold_d    = hold_q;
    accept    = 1'b0;
    push      = 1'b0;
    push_tag  = 1'b0;
    new_cmd   = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_i_req && bus.I_d_req) begin
          state_d = last_d_q ? ST_OWN_I : ST_OWN_D;
        end else if (bus.I_i_req) begin
          state_d = ST_OWN_I;
        end else if (bus.I_d_req) begin
          state_d = ST_OWN_D;
        end
      end
      ST_OWN_I, ST_OWN_D: begin
        // Full FIFO blocks a read even when a pop frees a slot this cycle,
        // which also keeps I_sdram_valid off the command path.
        accept = req_x & ~bus.I_sdram_busy & ~(read_x & fifo_full) & ~preempt;
        if (accept) begin
          new_cmd   = 1'b1;
          cmd_addr  = own_d ? bus.I_d_addr : bus.I_i_addr;
          cmd_we    = own_d & bus.I_d_we;
          cmd_wdata = own_d ? bus.I_d_wdata : 32'd0;
          hold_d    = (hold_q == HOLD_LIM) ? hold_q : hold_q + 1'b1;
          push      = read_x;
          push_tag  = own_d;
          if (own_d) d_busy = 1'b0;
          else       i_busy = 1'b0;
        end
        if ((~req_x & ~lock_x) | preempt) begin
          state_d  = ST_IDLE;
          last_d_d = own_d;
          hold_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response routing: the FIFO head names the port, independent of current owner
  always_comb begin
    pop      = bus.I_sdram_valid & ~fifo_empty;
    head_tag = tag_mem_q[rd_ptr_q];
  end

  assign bus.O_sdram_new_command = new_cmd;
  assign bus.O_sdram_addr        = cmd_addr;
  assign bus.O_sdram_we          = cmd_we;
  assign bus.O_sdram_wdata       = cmd_wdata;
  assign bus.O_i_busy            = i_busy;
  assign bus.O_d_busy            = d_busy;
  assign bus.O_i_valid           = pop & ~head_tag;
  assign bus.O_d_valid           = pop & head_tag;
  assign bus.O_i_data            = pop ? bus.I_sdram_data : 32'd0;
  assign bus.O_d_data            = pop ? bus.I_sdram_data : 32'd0;
  assign bus.O_err               = err_q;
  assign dbg_state_o             = state_q;

  // FSM, hold counter, FIFO pointers and sticky error
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b1;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      hold_q   <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.I_sdram_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage; contents are don't-care until written
  always_ff @(posedge I_clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= push_tag;
  end

endmodule
